// File: rtl/hazard_pkg.sv
// Shared constants and types for the D-stage hazard controller.
package hazard_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] FN_JR    = 6'd8;

  localparam int unsigned OP_HI = 31;
  localparam int unsigned OP_LO = 26;
  localparam int unsigned RS_HI = 25;
  localparam int unsigned RS_LO = 21;
  localparam int unsigned RT_HI = 20;
  localparam int unsigned RT_LO = 16;
  localparam int unsigned FN_HI = 5;
  localparam int unsigned FN_LO = 0;

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_BR_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use / jr data-hazard compare for the instruction in D.
module hazard_detect
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [31:0]       instr_d,
  input  logic [REG_AW-1:0] rd_e,
  input  logic              regwrite_e,
  input  logic [REG_AW-1:0] rt_e,
  input  logic              memread_e,
  input  logic [REG_AW-1:0] rd_m,
  input  logic              memread_m,
  output logic              data_stall
);

  logic              jr;
  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic              unused_instr_bits;

  // Register fields stay at the MIPS bit positions regardless of REG_AW.
  assign rs = REG_AW'(instr_d[RS_HI:RS_LO]);
  assign rt = REG_AW'(instr_d[RT_HI:RT_LO]);
  assign jr = (instr_d[OP_HI:OP_LO] == OP_RTYPE) && (instr_d[FN_HI:FN_LO] == FN_JR);
  assign unused_instr_bits = ^instr_d[15:6];

  always_comb begin
    data_stall = (jr && regwrite_e && (rs == rd_e))
              || (jr && memread_m  && (rs == rd_m))
              || (memread_e && ((rs == rt_e) || (rt == rt_e)));
  end

endmodule

// File: rtl/hazard_ctrl_fsm.sv
// Hazard controller: data stalls, branch-resolution FSM and memory hold.
// Optional perf counters enabled by defining HAZARD_PERF_EN.
module hazard_ctrl_fsm
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int BR_LAT = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       instr_d,
  input  logic              branch_d,
  input  logic [REG_AW-1:0] rd_e,
  input  logic              regwrite_e,
  input  logic [REG_AW-1:0] rt_e,
  input  logic              memread_e,
  input  logic [REG_AW-1:0] rd_m,
  input  logic              memread_m,
  input  logic              br_taken_m,
  input  logic              mem_busy,
  output logic              pc_write,
  output logic              fd_write,
  output logic              fd_flush,
  output logic              de_bubble,
  output logic              pipe_hold
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  state_t     state_q, state_d;
  logic [3:0] br_cnt_q, br_cnt_d;
  logic       data_stall;
  logic       resolve;

  hazard_detect #(.REG_AW(REG_AW)) u_detect (
    .instr_d    (instr_d),
    .rd_e       (rd_e),
    .regwrite_e (regwrite_e),
    .rt_e       (rt_e),
    .memread_e  (memread_e),
    .rd_m       (rd_m),
    .memread_m  (memread_m),
    .data_stall (data_stall)
  );

  assign resolve = (state_q == ST_BR_WAIT) && (br_cnt_q == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      br_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      br_cnt_q <= br_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    br_cnt_d = br_cnt_q;
    if (!mem_busy) begin
      case (state_q)
        ST_RUN: begin
          if (!data_stall && branch_d) begin
            state_d  = ST_BR_WAIT;
            br_cnt_d = 4'(BR_LAT - 1);
          end
        end
        ST_BR_WAIT: begin
          if (br_cnt_q != 4'd0) br_cnt_d = br_cnt_q - 4'd1;
          else                  state_d  = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_comb begin
    pc_write  = 1'b1;
    fd_write  = 1'b1;
    fd_flush  = 1'b0;
    de_bubble = 1'b0;
    pipe_hold = 1'b0;
    if (mem_busy) begin
      pipe_hold = 1'b1;
      pc_write  = 1'b0;
      fd_write  = 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (data_stall) begin
            pc_write  = 1'b0;
            fd_write  = 1'b0;
            de_bubble = 1'b1;
          end else if (branch_d) begin
            pc_write = 1'b0;
            fd_flush = 1'b1;
          end
        end
        ST_BR_WAIT: begin
          // Resolve cycle reloads PC; target vs fall-through is the datapath's choice.
          pc_write  = resolve;
          fd_flush  = 1'b1;
          de_bubble = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (!mem_busy) begin
      if ((state_q == ST_RUN) && data_stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (resolve && br_taken_m && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_fsm.sv
// Scoreboard bench for hazard_ctrl_fsm: directed scenarios then randomized traffic.
module tb_hazard_ctrl_fsm;

  localparam int REG_AW = 5;
  localparam int BR_LAT = 2;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [31:0]       instr_d = '0;
  logic              branch_d = 1'b0;
  logic [REG_AW-1:0] rd_e = '0;
  logic              regwrite_e = 1'b0;
  logic [REG_AW-1:0] rt_e = '0;
  logic              memread_e = 1'b0;
  logic [REG_AW-1:0] rd_m = '0;
  logic              memread_m = 1'b0;
  logic              br_taken_m = 1'b0;
  logic              mem_busy = 1'b0;
  logic              pc_write, fd_write, fd_flush, de_bubble, pipe_hold;
`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;
`endif

  always #5 clk = ~clk;

  hazard_ctrl_fsm #(.REG_AW(REG_AW), .BR_LAT(BR_LAT), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr_d    (instr_d),
    .branch_d   (branch_d),
    .rd_e       (rd_e),
    .regwrite_e (regwrite_e),
    .rt_e       (rt_e),
    .memread_e  (memread_e),
    .rd_m       (rd_m),
    .memread_m  (memread_m),
    .br_taken_m (br_taken_m),
    .mem_busy   (mem_busy),
    .pc_write   (pc_write),
    .fd_write   (fd_write),
    .fd_flush   (fd_flush),
    .de_bubble  (de_bubble),
    .pipe_hold  (pipe_hold)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
`endif
  );

  typedef struct {
    logic pc;
    logic fdw;
    logic fdw_chk;
    logic flush;
    logic bubble;
    logic hold;
    int   id;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;
  int step_id = 0;

  // Reference: number of branch-wait cycles still owed (0 = no branch in flight).
  int br_left = 0;
  longint stall_exp = 0;
  longint flush_exp = 0;
  longint cnt_max = (longint'(1) << CNT_W) - 1;

  task automatic check(input string name, input logic act, input logic exp, input int id);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s step %0d: got %0b expected %0b", name, id, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("pc_write",  pc_write,  e.pc,     e.id);
      if (e.fdw_chk) check("fd_write", fd_write, e.fdw, e.id);
      check("fd_flush",  fd_flush,  e.flush,  e.id);
      check("de_bubble", de_bubble, e.bubble, e.id);
      check("pipe_hold", pipe_hold, e.hold,   e.id);
    end
  end

  function automatic logic [31:0] mk_jr(input logic [4:0] rs);
    return {6'd0, rs, 15'd0, 6'd8};
  endfunction

  function automatic logic [31:0] mk_add(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    return {6'd0, rs, rt, rd, 5'd0, 6'd32};
  endfunction

  task automatic step(input logic [31:0] i, input logic br,
                      input logic [4:0] rde, input logic rwe,
                      input logic [4:0] rte, input logic mre,
                      input logic [4:0] rdm, input logic mrm,
                      input logic tk, input logic busy, input logic rn);
    exp_t e;
    logic is_jr, stall;
    logic [4:0] rs, rt;
    @(posedge clk);
    #1;
    instr_d = i; branch_d = br; rd_e = rde; regwrite_e = rwe; rt_e = rte;
    memread_e = mre; rd_m = rdm; memread_m = mrm; br_taken_m = tk;
    mem_busy = busy; rst_n = rn;

    if (!rn) br_left = 0;
    is_jr = (i[31:26] == 6'd0) && (i[5:0] == 6'd8);
    rs = i[25:21];
    rt = i[20:16];
    stall = (is_jr && rwe && rs == rde) || (is_jr && mrm && rs == rdm)
         || (mre && (rs == rte || rt == rte));

    e = '{pc: 1'b1, fdw: 1'b1, fdw_chk: 1'b1, flush: 1'b0, bubble: 1'b0, hold: 1'b0, id: step_id};
    if (busy) begin
      e.hold = 1'b1; e.pc = 1'b0; e.fdw = 1'b0;
    end else if (br_left > 0) begin
      e.flush = 1'b1; e.bubble = 1'b1; e.fdw_chk = 1'b0;
      e.pc = (br_left == 1);
    end else if (stall) begin
      e.pc = 1'b0; e.fdw = 1'b0; e.bubble = 1'b1;
    end else if (br) begin
      e.pc = 1'b0; e.flush = 1'b1; e.fdw_chk = 1'b0;
    end
    q.push_back(e);
    step_id++;

    if (!rn) begin
      stall_exp = 0;
      flush_exp = 0;
    end else if (!busy) begin
      if (br_left > 0) begin
        if (br_left == 1 && tk && flush_exp < cnt_max) flush_exp++;
        br_left--;
      end else if (stall) begin
        if (stall_exp < cnt_max) stall_exp++;
      end else if (br) begin
        br_left = BR_LAT;
      end
    end
  endtask

  task automatic quiet(input logic br, input logic tk, input logic busy, input logic rn);
    step(32'd0, br, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, tk, busy, rn);
  endtask

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 4))
      0: return 5'd0;
      1: return 5'd1;
      2: return 5'd2;
      3: return 5'd3;
      default: return 5'd31;
    endcase
  endfunction

  initial begin
    logic [31:0] ri;
    // Reset with quiet inputs, then release.
    quiet(1'b0, 1'b0, 1'b0, 1'b0);
    quiet(1'b0, 1'b0, 1'b0, 1'b0);
    quiet(1'b0, 1'b0, 1'b0, 1'b1);
    // Load-use: lw r2 in E, add r3,r2,r4 in D.
    step(mk_add(5'd3, 5'd2, 5'd4), 1'b0, 5'd0, 1'b0, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(mk_add(5'd3, 5'd2, 5'd4), 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    // jr r31 against E writer then M load.
    step(mk_jr(5'd31), 1'b0, 5'd31, 1'b1, 5'd0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1);
    step(mk_jr(5'd31), 1'b0, 5'd0,  1'b0, 5'd0, 1'b0, 5'd31, 1'b1, 1'b0, 1'b0, 1'b1);
    step(mk_jr(5'd31), 1'b0, 5'd0,  1'b0, 5'd0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1);
    // Stall and branch together: stall first, then accept.
    step(mk_add(5'd3, 5'd2, 5'd4), 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    quiet(1'b1, 1'b0, 1'b0, 1'b1);
    quiet(1'b0, 1'b0, 1'b0, 1'b1);
    quiet(1'b0, 1'b1, 1'b0, 1'b1);
    // Taken then not-taken branch.
    quiet(1'b1, 1'b0, 1'b0, 1'b1);
    quiet(1'b0, 1'b0, 1'b0, 1'b1);
    quiet(1'b0, 1'b1, 1'b0, 1'b1);
    quiet(1'b1, 1'b0, 1'b0, 1'b1);
    quiet(1'b0, 1'b0, 1'b0, 1'b1);
    quiet(1'b0, 1'b0, 1'b0, 1'b1);
    quiet(1'b0, 1'b0, 1'b0, 1'b1);
    // mem_busy for 3 cycles right after accept.
    quiet(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (3) quiet(1'b0, 1'b0, 1'b1, 1'b1);
    quiet(1'b0, 1'b0, 1'b0, 1'b1);
    quiet(1'b0, 1'b1, 1'b0, 1'b1);
    quiet(1'b0, 1'b0, 1'b0, 1'b1);
    // Reset during BR_WAIT, then a fresh branch.
    quiet(1'b1, 1'b0, 1'b0, 1'b1);
    quiet(1'b0, 1'b0, 1'b0, 1'b0);
    quiet(1'b1, 1'b0, 1'b0, 1'b1);
    quiet(1'b0, 1'b0, 1'b0, 1'b1);
    quiet(1'b0, 1'b0, 1'b0, 1'b1);
    quiet(1'b0, 1'b0, 1'b0, 1'b1);

    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 2))
        0: ri = mk_jr(pick_reg());
        1: ri = mk_add(pick_reg(), pick_reg(), pick_reg());
        default: ri = $urandom;
      endcase
      step(ri, ($urandom_range(0, 9) < 3), pick_reg(), ($urandom_range(0, 1) == 1),
           pick_reg(), ($urandom_range(0, 9) < 3), pick_reg(), ($urandom_range(0, 9) < 3),
           ($urandom_range(0, 1) == 1), ($urandom_range(0, 99) < 15),
           ($urandom_range(0, 99) >= 2));
    end

    @(posedge clk);
    @(posedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
`ifdef HAZARD_PERF_EN
    tests++;
    if (longint'(stall_cnt) != stall_exp) begin
      fails++;
      $display("FAIL stall_cnt: got %0d expected %0d", stall_cnt, stall_exp);
    end
    tests++;
    if (longint'(flush_cnt) != flush_exp) begin
      fails++;
      $display("FAIL flush_cnt: got %0d expected %0d", flush_cnt, flush_exp);
    end
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
